// File: rtl/riscv_pkg.sv
// Shared constants and encodings for the RV32I pipeline slice.
package riscv_pkg;

  localparam int unsigned CORE_XLEN = 32;
  localparam int unsigned CORE_RA_W = 5;
  localparam int unsigned ALUCTRL_W = 3;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

endpackage

// File: rtl/ld_use_detect.sv
// Combinational load-use hazard detection between the E-stage load and D-stage sources.
module ld_use_detect
  import riscv_pkg::*;
#(
  parameter int unsigned RA_W = CORE_RA_W
) (
  input  logic            valid_e,
  input  logic            reg_write_e,
  input  logic [1:0]      result_src_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  output logic            lduse
);

  always_comb begin
    lduse = valid_e && reg_write_e && (result_src_e == RES_LOAD) &&
            (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with write-back bypass, load-use bubbling and flush/stall control.
module id_ex_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN,
  parameter int unsigned RA_W = CORE_RA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [RA_W-1:0]      Rs1D,
  input  logic [RA_W-1:0]      Rs2D,
  input  logic [RA_W-1:0]      RdD,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [1:0]           ResultSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic                 RegWriteW,
  input  logic [RA_W-1:0]      RdW,
  input  logic [XLEN-1:0]      ResultW,
  input  logic                 FlushE,
  input  logic                 StallE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 ValidE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [RA_W-1:0]      Rs1E,
  output logic [RA_W-1:0]      Rs2E,
  output logic [RA_W-1:0]      RdE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE
);

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc4;
    logic [XLEN-1:0]      imm;
    logic [RA_W-1:0]      rs1;
    logic [RA_W-1:0]      rs2;
    logic [RA_W-1:0]      rd;
    logic                 reg_write;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic [1:0]           result_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;
  } e_stage_t;

  e_stage_t        e_q;
  logic [XLEN-1:0] op1, op2;
  logic            lduse;

  // x0 reads as zero; otherwise a same-edge register-file write is forwarded.
  always_comb begin
    op1 = RD1D;
    if (Rs1D == '0)
      op1 = '0;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1D))
      op1 = ResultW;

    op2 = RD2D;
    if (Rs2D == '0)
      op2 = '0;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2D))
      op2 = ResultW;
  end

  ld_use_detect #(
    .RA_W (RA_W)
  ) u_ld_use_detect (
    .valid_e      (e_q.valid),
    .reg_write_e  (e_q.reg_write),
    .result_src_e (e_q.result_src),
    .rd_e         (e_q.rd),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .lduse        (lduse)
  );

  assign StallF = lduse | StallE;
  assign StallD = lduse | StallE;

  // Flush outranks stall; a load-use bubble only applies when E is not held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
    end else if (FlushE || (!StallE && lduse)) begin
      e_q <= '0;
    end else if (!StallE) begin
      e_q <= '{valid: 1'b1, rd1: op1, rd2: op2, pc: PCD, pc4: PCPlus4D,
               imm: ImmExtD, rs1: Rs1D, rs2: Rs2D, rd: RdD,
               reg_write: RegWriteD, mem_write: MemWriteD, jump: JumpD,
               branch: BranchD, alu_src: ALUSrcD, result_src: ResultSrcD,
               alu_ctrl: ALUControlD};
    end
  end

  assign ValidE      = e_q.valid;
  assign RD1E        = e_q.rd1;
  assign RD2E        = e_q.rd2;
  assign PCE         = e_q.pc;
  assign PCPlus4E    = e_q.pc4;
  assign ImmExtE     = e_q.imm;
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;
  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign JumpE       = e_q.jump;
  assign BranchE     = e_q.branch;
  assign ALUSrcE     = e_q.alu_src;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = e_q.alu_ctrl;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD, RdW;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, RegWriteW;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic        FlushE, StallE;
  logic        StallF, StallD, ValidE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .FlushE(FlushE), .StallE(StallE),
    .StallF(StallF), .StallD(StallD), .ValidE(ValidE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE)
  );

  // Expected content of the E stage, kept as one instruction record.
  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, j, b, as;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
  } e_t;

  e_t m;

  function automatic e_t dut_e();
    return e_t'({ValidE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
                 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
                 ALUControlE});
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return ResultW;
    return rf;
  endfunction

  function automatic logic model_lduse();
    return m.valid && m.rw && m.rsrc == 2'b01 && m.rd != 5'd0 &&
           (m.rd == Rs1D || m.rd == Rs2D);
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    RD1D = '0; RD2D = '0; PCD = '0; PCPlus4D = '0; ImmExtD = '0; ResultW = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0; RdW = '0;
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0; RegWriteW = 0;
    ResultSrcD = '0; ALUControlD = '0; FlushE = 0; StallE = 0;
  endtask

  // Called just after a rising edge with D inputs applied; checks stall, clocks, checks E.
  task automatic step(input string tag);
    logic exp_stall;
    e_t   nxt;
    #1;
    exp_stall = model_lduse() || StallE;
    chk({tag, "_stall"}, {190'd0, StallF, StallD}, {190'd0, exp_stall, exp_stall});
    if (FlushE) nxt = '0;
    else if (StallE) nxt = m;
    else if (model_lduse()) nxt = '0;
    else nxt = '{valid: 1'b1, rd1: operand(Rs1D, RD1D), rd2: operand(Rs2D, RD2D),
                 pc: PCD, pc4: PCPlus4D, imm: ImmExtD, rs1: Rs1D, rs2: Rs2D, rd: RdD,
                 rw: RegWriteD, mw: MemWriteD, j: JumpD, b: BranchD, as: ALUSrcD,
                 rsrc: ResultSrcD, alu: ALUControlD};
    @(posedge clk);
    m = nxt;
    #1;
    chk({tag, "_e"}, {6'd0, dut_e()}, {6'd0, m});
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_e", {6'd0, dut_e()}, 192'd0);
    chk("reset_stall", {190'd0, StallF, StallD}, 192'd0);
    rst = 1'b0;

    // Normal flow
    RD1D = 32'h11; RD2D = 32'h22; RegWriteD = 1; RdD = 5'd5; Rs1D = 5'd1; Rs2D = 5'd2;
    PCD = 32'h100; PCPlus4D = 32'h104; ImmExtD = 32'hFFFF_FFF0; ALUControlD = 3'd2;
    step("normal");
    chk("normal_rd1", {160'd0, RD1E}, {160'd0, 32'h11});
    chk("normal_ctl", {185'd0, ValidE, RegWriteE, RdE}, {185'd0, 1'b1, 1'b1, 5'd5});

    // Write-back bypass and its exclusions
    set_idle();
    Rs1D = 5'd7; RD1D = 32'hDEAD; RegWriteW = 1; RdW = 5'd7; ResultW = 32'hBEEF;
    step("byp_hit");
    chk("byp_hit_rd1", {160'd0, RD1E}, {160'd0, 32'hBEEF});
    RdW = 5'd0;
    step("byp_rdw0");
    chk("byp_rdw0_rd1", {160'd0, RD1E}, {160'd0, 32'hDEAD});
    RdW = 5'd7; Rs1D = 5'd0;
    step("byp_rs0");
    chk("byp_rs0_rd1", {160'd0, RD1E}, 192'd0);
    Rs1D = 5'd9; Rs2D = 5'd9; RdW = 5'd9; RD2D = 32'h1234;
    step("byp_rs2");
    chk("byp_rs2_rd2", {160'd0, RD2E}, {160'd0, 32'hBEEF});

    // Load-use: load x3, then a store using x3 as rs2
    set_idle();
    RegWriteD = 1; ResultSrcD = 2'b01; RdD = 5'd3; Rs1D = 5'd4;
    step("ld");
    set_idle();
    MemWriteD = 1; Rs1D = 5'd6; Rs2D = 5'd3; RD2D = 32'h55; PCD = 32'h200;
    #1;
    chk("lu_stall_hi", {190'd0, StallF, StallD}, {190'd0, 2'b11});
    step("lu_bubble");
    chk("lu_bubble_ctl", {189'd0, ValidE, RegWriteE, MemWriteE}, 192'd0);
    step("lu_dep");
    chk("lu_dep_in", {159'd0, ValidE, PCE}, {159'd0, 1'b1, 32'h200});

    // Load to x0 and to a non-matching register: no bubble
    set_idle();
    RegWriteD = 1; ResultSrcD = 2'b01; RdD = 5'd0;
    step("ld_x0");
    set_idle();
    Rs1D = 5'd0; Rs2D = 5'd0; RegWriteD = 1; RdD = 5'd8; ResultSrcD = 2'b01;
    step("ld_x0_use");
    set_idle();
    Rs1D = 5'd2; Rs2D = 5'd9;
    step("ld_nomatch");
    chk("ld_nomatch_v", {191'd0, ValidE}, {191'd0, 1'b1});

    // Flush beats stall
    set_idle();
    RegWriteD = 1; RdD = 5'd12; RD1D = 32'hA5A5; Rs1D = 5'd1;
    step("pre_flush");
    FlushE = 1; StallE = 1;
    step("flush_stall");
    chk("flush_stall_v", {191'd0, ValidE}, 192'd0);
    FlushE = 0; StallE = 0;
    step("refill");
    StallE = 1; RD1D = 32'h7777; RdD = 5'd13; PCD = 32'h444;
    for (int i = 0; i < 3; i++) step("hold3");

    // Async reset mid-cycle while E is valid
    StallE = 0;
    step("pre_rst");
    #2 rst = 1'b1;
    #1;
    m = '0;
    chk("async_rst", {6'd0, dut_e()}, 192'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step("post_rst");

    // Randomized traffic, narrow register range to provoke hazards and bypasses
    for (int i = 0; i < 400; i++) begin
      RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom;
      ImmExtD = $urandom; ResultW = $urandom;
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      RdD = 5'($urandom_range(0, 7)); RdW = 5'($urandom_range(0, 7));
      RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom);
      BranchD = 1'($urandom); ALUSrcD = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcD = 2'($urandom_range(0, 2)); ALUControlD = 3'($urandom);
      FlushE = ($urandom_range(0, 9) == 0);
      StallE = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
